// File: rtl/control_pipe_pkg.sv
// control_pipe_pkg: shared encodings and control-bundle types for the
// LAMBA pipelined control unit (opcodes, functs, mux selects, FSM states).
package control_pipe_pkg;

    // Opcode encodings
    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J_TYPE = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_JT     = 6'h06;
    localparam logic [5:0] OP_JF     = 6'h07;
    localparam logic [5:0] OP_LOAD   = 6'h23;
    localparam logic [5:0] OP_STORE  = 6'h2B;

    // R-type funct / ALU operation encodings
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_DIV = 6'h1A;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    typedef enum logic [1:0] {
        DST_RT  = 2'd0,
        DST_RD  = 2'd1,
        DST_R15 = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC1 = 2'd2
    } wb_res_e;

    typedef enum logic {
        CP_IDLE   = 1'b0,
        CP_MC_RUN = 1'b1
    } cp_state_e;

    typedef struct packed {
        logic     is_jump;
        logic     alu_src_mux;
        logic     sel_j_jr;
        reg_dst_e reg_dst;
    } ex_ctrl_t;

    typedef struct packed {
        logic write_enable;
        logic sel_beq_bne;
        logic fl_write_enable;
        logic sel_jt_jf;
        logic is_branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic    reg_write_enable;
        wb_res_e res_mux;
    } wb_ctrl_t;

    // Full decoded bundle (alu_funct travels separately: its width is a parameter)
    typedef struct packed {
        logic      valid;
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    typedef struct packed {
        logic      valid;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } mem_stage_t;

    typedef struct packed {
        logic     valid;
        wb_ctrl_t wb;
    } wb_stage_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational opcode/funct -> fully defaulted
// control bundle, plus illegal-opcode and multi-cycle-funct flags.
// Ports: opcode, funct in; ctrl_c, alu_funct_c, is_illegal_c, is_multicycle_c out.
module control_decode
    import control_pipe_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output ctrl_t               ctrl_c,
    output logic [FUNCT_W-1:0]  alu_funct_c,
    output logic                is_illegal_c,
    output logic                is_multicycle_c
);

    always_comb begin
        ctrl_c                = '0;
        ctrl_c.valid          = 1'b1;
        ctrl_c.ex.alu_src_mux = 1'b1;
        ctrl_c.ex.reg_dst     = DST_RT;
        ctrl_c.wb.res_mux     = WB_ALU;
        alu_funct_c           = FUNCT_W'(FN_ADD);
        is_illegal_c          = 1'b0;
        is_multicycle_c       = 1'b0;

        case (opcode)
            OPCODE_W'(OP_STORE): ctrl_c.mem.write_enable = 1'b1;
            OPCODE_W'(OP_LOAD): begin
                ctrl_c.wb.res_mux          = WB_MEM;
                ctrl_c.wb.reg_write_enable = 1'b1;
            end
            OPCODE_W'(OP_J_TYPE): begin
                ctrl_c.ex.is_jump  = 1'b1;
                ctrl_c.ex.sel_j_jr = 1'b1;
            end
            OPCODE_W'(OP_JAL): begin
                ctrl_c.ex.is_jump          = 1'b1;
                ctrl_c.ex.reg_dst          = DST_R15;
                ctrl_c.wb.reg_write_enable = 1'b1;
                ctrl_c.wb.res_mux          = WB_PC1;
            end
            OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE): begin
                ctrl_c.mem.is_branch   = 1'b1;
                ctrl_c.mem.sel_beq_bne = (opcode == OPCODE_W'(OP_BNE));
                alu_funct_c            = FUNCT_W'(FN_SUB);
            end
            OPCODE_W'(OP_JT), OPCODE_W'(OP_JF): begin
                ctrl_c.mem.is_branch = 1'b1;
                ctrl_c.mem.sel_jt_jf = (opcode == OPCODE_W'(OP_JT));
            end
            OPCODE_W'(OP_R_TYPE): begin
                ctrl_c.ex.reg_dst     = DST_RD;
                ctrl_c.ex.alu_src_mux = 1'b0;
                if (funct == FUNCT_W'(FN_JR)) begin
                    // jr: jump through register, nothing written back
                    ctrl_c.ex.is_jump  = 1'b1;
                    ctrl_c.ex.sel_j_jr = 1'b0;
                end else begin
                    alu_funct_c                = funct;
                    ctrl_c.wb.reg_write_enable = 1'b1;
                    ctrl_c.mem.fl_write_enable = 1'b1;
                    is_multicycle_c = (funct == FUNCT_W'(FN_MUL)) ||
                                      (funct == FUNCT_W'(FN_DIV));
                end
            end
            default: begin
                // Unknown opcode decodes to a bubble
                ctrl_c       = '0;
                alu_funct_c  = '0;
                is_illegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: pipelined control unit. Registers the decoded bundle into EX,
// then forwards MEM and WB slices; handles stall/flush bubbles, a counter-driven
// EX hold for multi-cycle ALU functs, and a sticky illegal-opcode flag.
// Ports: clk, rst_n (sync, active-low), id_valid/opcode/funct from ID,
// stall/flush from hazard logic; EX/MEM/WB control slices, mc_busy, illegal_op out.
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned MC_LAT   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                stall,
    input  logic                flush,
    output logic                ex_valid,
    output logic                ex_is_jump,
    output logic                ex_alu_src_mux,
    output logic                ex_sel_j_jr,
    output logic [FUNCT_W-1:0]  ex_alu_funct,
    output logic [1:0]          ex_reg_dst_mux,
    output logic                mem_valid,
    output logic                mem_write_enable,
    output logic                mem_sel_beq_bne,
    output logic                mem_fl_write_enable,
    output logic                mem_sel_jt_jf,
    output logic                mem_is_branch,
    output logic                wb_valid,
    output logic                wb_reg_write_enable,
    output logic [1:0]          wb_res_mux,
    output logic                mc_busy,
    output logic                illegal_op
);

    localparam int unsigned CNT_W = $clog2(MC_LAT + 1);

    ctrl_t              dec_ctrl;
    logic [FUNCT_W-1:0] dec_funct;
    logic               dec_illegal;
    logic               dec_mc;

    ctrl_t              ex_ctrl_q,  ex_ctrl_d;
    logic [FUNCT_W-1:0] ex_funct_q, ex_funct_d;
    mem_stage_t         mem_q,      mem_d;
    wb_stage_t          wb_q,       wb_d;
    cp_state_e          state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               illegal_q,  illegal_d;

    control_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_decode (
        .opcode          (opcode),
        .funct           (funct),
        .ctrl_c          (dec_ctrl),
        .alu_funct_c     (dec_funct),
        .is_illegal_c    (dec_illegal),
        .is_multicycle_c (dec_mc)
    );

    // Next-state: EX hold > bubble (flush/stall/no instr) > advance
    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_funct_d = ex_funct_q;
        mem_d      = mem_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;

        // MEM always drains into WB
        wb_d.valid = mem_q.valid;
        wb_d.wb    = mem_q.wb;

        if (state_q == CP_MC_RUN) begin
            mem_d = '0;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = CP_IDLE;
            end
        end else begin
            mem_d.valid = ex_ctrl_q.valid;
            mem_d.mem   = ex_ctrl_q.mem;
            mem_d.wb    = ex_ctrl_q.wb;
            if (!id_valid || flush || stall) begin
                ex_ctrl_d  = '0;
                ex_funct_d = '0;
            end else begin
                // Decoder already returns a bubble for unknown opcodes
                ex_ctrl_d  = dec_ctrl;
                ex_funct_d = dec_funct;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                end
                if (dec_mc) begin
                    state_d = CP_MC_RUN;
                    cnt_d   = CNT_W'(MC_LAT);
                end
            end
        end
    end

    // Stage registers, FSM, counter and sticky flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctrl_q  <= '0;
            ex_funct_q <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            state_q    <= CP_IDLE;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_funct_q <= ex_funct_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid            = ex_ctrl_q.valid;
    assign ex_is_jump          = ex_ctrl_q.ex.is_jump;
    assign ex_alu_src_mux      = ex_ctrl_q.ex.alu_src_mux;
    assign ex_sel_j_jr         = ex_ctrl_q.ex.sel_j_jr;
    assign ex_alu_funct        = ex_funct_q;
    assign ex_reg_dst_mux      = ex_ctrl_q.ex.reg_dst;
    assign mem_valid           = mem_q.valid;
    assign mem_write_enable    = mem_q.mem.write_enable;
    assign mem_sel_beq_bne     = mem_q.mem.sel_beq_bne;
    assign mem_fl_write_enable = mem_q.mem.fl_write_enable;
    assign mem_sel_jt_jf       = mem_q.mem.sel_jt_jf;
    assign mem_is_branch       = mem_q.mem.is_branch;
    assign wb_valid            = wb_q.valid;
    assign wb_reg_write_enable = wb_q.wb.reg_write_enable;
    assign wb_res_mux          = wb_q.wb.res_mux;
    assign mc_busy             = (state_q == CP_MC_RUN);
    assign illegal_op          = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed-vector bench for control_pipe with a behavioural
// pipeline model (decode table + countdown hold) compared every cycle, plus
// hand-computed literal expectations.
module tb_control_pipe;
    import control_pipe_pkg::*;

    localparam int MC_LAT = 4;

    logic       clk, rst_n, id_valid, stall, flush;
    logic [5:0] opcode, funct;
    logic       ex_valid, ex_is_jump, ex_alu_src_mux, ex_sel_j_jr;
    logic [5:0] ex_alu_funct;
    logic [1:0] ex_reg_dst_mux;
    logic       mem_valid, mem_write_enable, mem_sel_beq_bne, mem_fl_write_enable;
    logic       mem_sel_jt_jf, mem_is_branch;
    logic       wb_valid, wb_reg_write_enable;
    logic [1:0] wb_res_mux;
    logic       mc_busy, illegal_op;

    control_pipe #(.OPCODE_W(6), .FUNCT_W(6), .MC_LAT(MC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_alu_src_mux(ex_alu_src_mux),
        .ex_sel_j_jr(ex_sel_j_jr), .ex_alu_funct(ex_alu_funct), .ex_reg_dst_mux(ex_reg_dst_mux),
        .mem_valid(mem_valid), .mem_write_enable(mem_write_enable),
        .mem_sel_beq_bne(mem_sel_beq_bne), .mem_fl_write_enable(mem_fl_write_enable),
        .mem_sel_jt_jf(mem_sel_jt_jf), .mem_is_branch(mem_is_branch),
        .wb_valid(wb_valid), .wb_reg_write_enable(wb_reg_write_enable), .wb_res_mux(wb_res_mux),
        .mc_busy(mc_busy), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction's worth of control, as the decode table describes it
    typedef struct packed {
        logic       valid, is_jump, alu_src, sel_j_jr;
        logic [5:0] funct;
        logic [1:0] reg_dst;
        logic       mem_we, beq_bne, fl_we, jt_jf, is_branch, reg_we;
        logic [1:0] wb_res;
    } rec_t;

    rec_t m_ex, m_mem, m_wb;
    int   m_busy_left;
    logic m_ill;
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic known_op(input logic [5:0] op);
        return op inside {OP_R_TYPE, OP_LOAD, OP_STORE, OP_J_TYPE, OP_JAL,
                          OP_BEQ, OP_BNE, OP_JT, OP_JF};
    endfunction

    function automatic rec_t model_decode(input logic [5:0] op, input logic [5:0] fn);
        rec_t r = '0;
        r.valid   = 1'b1;
        r.alu_src = 1'b1;
        r.funct   = FN_ADD;
        case (op)
            OP_STORE:  r.mem_we = 1'b1;
            OP_LOAD:   begin r.wb_res = 2'd1; r.reg_we = 1'b1; end
            OP_J_TYPE: begin r.is_jump = 1'b1; r.sel_j_jr = 1'b1; end
            OP_JAL:    begin r.is_jump = 1'b1; r.reg_dst = 2'd2; r.reg_we = 1'b1; r.wb_res = 2'd2; end
            OP_BEQ:    begin r.is_branch = 1'b1; r.beq_bne = 1'b0; r.funct = FN_SUB; end
            OP_BNE:    begin r.is_branch = 1'b1; r.beq_bne = 1'b1; r.funct = FN_SUB; end
            OP_JT:     begin r.is_branch = 1'b1; r.jt_jf = 1'b1; end
            OP_JF:     begin r.is_branch = 1'b1; r.jt_jf = 1'b0; end
            OP_R_TYPE: begin
                r.reg_dst = 2'd1;
                r.alu_src = 1'b0;
                if (fn == FN_JR) r.is_jump = 1'b1;
                else begin r.funct = fn; r.reg_we = 1'b1; r.fl_we = 1'b1; end
            end
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Advance the model by one rising edge using the inputs the DUT sees
    task automatic model_edge();
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_busy_left = 0; m_ill = 1'b0;
        end else begin
            m_wb = m_mem;
            if (m_busy_left > 0) begin
                m_mem = '0;
                m_busy_left--;
            end else begin
                m_mem = m_ex;
                if (!id_valid || flush || stall) m_ex = '0;
                else begin
                    m_ex = model_decode(opcode, funct);
                    if (!known_op(opcode)) m_ill = 1'b1;
                    if (opcode == OP_R_TYPE && (funct == FN_MUL || funct == FN_DIV))
                        m_busy_left = MC_LAT;
                end
            end
        end
    endtask

    function automatic logic [23:0] model_vec();
        return {m_ex.valid, m_ex.is_jump, m_ex.alu_src, m_ex.sel_j_jr, m_ex.funct, m_ex.reg_dst,
                m_mem.valid, m_mem.mem_we, m_mem.beq_bne, m_mem.fl_we, m_mem.jt_jf, m_mem.is_branch,
                m_wb.valid, m_wb.reg_we, m_wb.wb_res,
                (m_busy_left > 0), m_ill};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {ex_valid, ex_is_jump, ex_alu_src_mux, ex_sel_j_jr, ex_alu_funct, ex_reg_dst_mux,
                mem_valid, mem_write_enable, mem_sel_beq_bne, mem_fl_write_enable, mem_sel_jt_jf,
                mem_is_branch, wb_valid, wb_reg_write_enable, wb_res_mux, mc_busy, illegal_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // One clock: model follows the edge, then the whole output vector is compared
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cycle", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn);
        id_valid = v; opcode = op; funct = fn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed { logic [5:0] op; logic [5:0] fn; } instr_t;

    initial begin
        int busy_n, mul_n, bub_n;
        instr_t mix [8];
        mix[0] = '{OP_STORE,  6'h00};
        mix[1] = '{OP_J_TYPE, 6'h00};
        mix[2] = '{OP_BEQ,    6'h00};
        mix[3] = '{OP_BNE,    6'h00};
        mix[4] = '{OP_JT,     6'h00};
        mix[5] = '{OP_JF,     6'h00};
        mix[6] = '{OP_R_TYPE, FN_AND};
        mix[7] = '{OP_R_TYPE, FN_DIV};

        m_ex = '0; m_mem = '0; m_wb = '0; m_busy_left = 0; m_ill = 1'b0;
        // Reset with junk on the inputs
        rst_n = 1'b0; flush = 1'b1; stall = 1'b0;
        set_id(1'b1, 6'h3F, FN_MUL);
        step();
        chk("reset_all_zero", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1; flush = 1'b0;

        // LOAD through all three slices
        set_id(1'b1, OP_LOAD, 6'h00); step();
        chk("load_ex_valid", 32'(ex_valid), 32'd1);
        chk("load_ex_alu_src", 32'(ex_alu_src_mux), 32'd1);
        set_id(1'b0, 6'h00, 6'h00); step();
        chk("load_mem_valid", 32'(mem_valid), 32'd1);
        step();
        chk("load_wb_res", 32'(wb_res_mux), 32'd1);
        chk("load_wb_we", 32'(wb_reg_write_enable), 32'd1);

        // JAL then jr
        set_id(1'b1, OP_JAL, 6'h00); step();
        chk("jal_jump", 32'(ex_is_jump), 32'd1);
        chk("jal_dst", 32'(ex_reg_dst_mux), 32'd2);
        chk("jal_sel", 32'(ex_sel_j_jr), 32'd0);
        set_id(1'b1, OP_R_TYPE, FN_JR); step();
        chk("jr_jump", 32'(ex_is_jump), 32'd1);
        chk("jr_dst", 32'(ex_reg_dst_mux), 32'd1);
        chk("jr_sel", 32'(ex_sel_j_jr), 32'd0);
        set_id(1'b0, 6'h00, 6'h00); step();
        chk("jal_wb_we", 32'(wb_reg_write_enable), 32'd1);
        step();
        chk("jr_wb_we", 32'(wb_reg_write_enable), 32'd0);
        step();

        // MUL followed by ADD held in ID
        set_id(1'b1, OP_R_TYPE, FN_MUL); step();
        busy_n = int'(mc_busy); mul_n = int'(ex_alu_funct == FN_MUL); bub_n = 0;
        set_id(1'b1, OP_R_TYPE, FN_ADD);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i <= 4) begin
                busy_n += int'(mc_busy);
                mul_n  += int'(ex_alu_funct == FN_MUL);
                bub_n  += int'(!mem_valid);
            end
        end
        chk("mul_busy_cycles", 32'(busy_n), 32'd4);
        chk("mul_ex_cycles", 32'(mul_n), 32'd5);
        chk("mul_mem_bubbles", 32'(bub_n), 32'd4);
        chk("add_in_ex_t5", 32'(ex_alu_funct), 32'(FN_ADD));
        chk("mul_in_mem_t5", 32'(mem_valid), 32'd1);
        set_id(1'b0, 6'h00, 6'h00); step(); step();

        // Back-to-back multi-cycle ops
        set_id(1'b1, OP_R_TYPE, FN_MUL);
        for (int i = 0; i <= 5; i++) step();
        chk("b2b_rearm", 32'(mc_busy), 32'd1);
        set_id(1'b0, 6'h00, 6'h00);
        for (int i = 0; i < 6; i++) step();

        // Remaining opcodes, one per cycle (DIV last, then drain)
        foreach (mix[i]) begin
            set_id(1'b1, mix[i].op, mix[i].fn); step();
        end
        set_id(1'b0, 6'h00, 6'h00);
        for (int i = 0; i < 7; i++) step();

        // Stall twice, then SUB advances exactly once
        set_id(1'b1, OP_R_TYPE, FN_SUB); stall = 1'b1;
        step(); chk("stall_bubble0", 32'(ex_valid), 32'd0);
        step(); chk("stall_bubble1", 32'(ex_valid), 32'd0);
        stall = 1'b0; step();
        chk("sub_adv_funct", 32'(ex_alu_funct), 32'(FN_SUB));
        set_id(1'b0, 6'h00, 6'h00); step();
        chk("sub_once", 32'(ex_valid), 32'd0);

        // Flush squashes SUB; flush+stall together also bubbles
        set_id(1'b1, OP_R_TYPE, FN_SUB); flush = 1'b1;
        step(); chk("flush_bubble", 32'(ex_valid), 32'd0);
        flush = 1'b0; set_id(1'b0, 6'h00, 6'h00);
        step(); step(); step();
        set_id(1'b1, OP_R_TYPE, FN_SUB); flush = 1'b1; stall = 1'b1;
        step(); chk("flush_stall_bubble", 32'(ex_valid), 32'd0);
        flush = 1'b0; stall = 1'b0; set_id(1'b0, 6'h00, 6'h00); step();

        // Unknown opcode: invalid one is ignored, valid one sets sticky flag
        set_id(1'b0, 6'h3F, 6'h00); step();
        chk("illegal_ignored", 32'(illegal_op), 32'd0);
        set_id(1'b1, 6'h3F, 6'h00); step();
        chk("illegal_set", 32'(illegal_op), 32'd1);
        chk("illegal_bubble", 32'(ex_valid), 32'd0);
        set_id(1'b0, 6'h00, 6'h00);
        for (int i = 0; i < 4; i++) step();
        chk("illegal_sticky", 32'(illegal_op), 32'd1);

        // Reset in the second MC_RUN cycle
        set_id(1'b1, OP_R_TYPE, FN_MUL); step();
        set_id(1'b1, OP_R_TYPE, FN_ADD); step();
        chk("mc_second_cycle", 32'(mc_busy), 32'd1);
        rst_n = 1'b0; step();
        chk("mc_reset_zero", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;
        set_id(1'b1, OP_LOAD, 6'h00); step();
        chk("post_reset_load", 32'(ex_valid), 32'd1);
        set_id(1'b0, 6'h00, 6'h00); step(); step();
        chk("post_reset_load_wb", 32'(wb_res_mux), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
